rotator_left_seq: RTL
=====================

ROTATOR_LEFT_SEQ -- requirements
Module: rotator_left_seq

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (WIDTH >= 2) SHALL be provided.
REQ-002 Parameter AMT_W, default 2, width of rotate-amount field SHALL be provided.
REQ-003 Port clk  input  1  sole clock, all state on rising edge SHALL be provided.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low SHALL be provided.
REQ-005 Port in_valid  input  1  request presented SHALL be provided.
REQ-006 Port in_ready  output  1  block can accept request SHALL be provided.
REQ-007 Port data  input  WIDTH  word to rotate, sampled only on accept SHALL be provided.
REQ-008 Port select  input  AMT_W  left-rotate amount in bit positions, sampled only on accept SHALL be provided.
REQ-009 Port out_valid  output  1  result available SHALL be provided.
REQ-010 Port out_ready  input  1  consumer takes result SHALL be provided.
REQ-011 Port out  output  WIDTH  rotated result SHALL be provided.
REQ-012 Port busy  output  1  high in any state other than IDLE SHALL be provided.

Function
REQ-013 The block SHALL implement FSM states IDLE, ROTATE, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; accept occurs on a rising edge with in_valid && in_ready.
REQ-015 On accept: working register <= data, counter <= select; next state ROTATE if select != 0, else DONE.
REQ-016 Each ROTATE cycle: working register <= {reg[WIDTH-2:0], reg[WIDTH-1]} (rotate left by 1), counter decrements by 1.
REQ-017 ROTATE -> DONE on the edge where the counter goes from 1 to 0; no extra idle step.
REQ-018 Latency, accept edge to out_valid high, SHALL be 1 + select cycles (select = 0 gives 1 cycle).
REQ-019 In DONE: out_valid = 1, out = working register, held stable until handshake.
REQ-020 DONE -> IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle re-accept).
REQ-021 out_ready low in DONE SHALL hold state, out and out_valid indefinitely.
REQ-022 in_valid, data, select changes while busy SHALL be ignored and SHALL NOT affect the result.
REQ-023 out_valid SHALL be 0 in IDLE and ROTATE; out SHALL hold the last working-register value (no X) in all states.
REQ-024 Rotation SHALL be modulo WIDTH: select >= WIDTH yields the same result as select mod WIDTH, still costing select cycles.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, working register 0, counter 0, out 0, out_valid 0, busy 0, in_ready 1 (after release).
REQ-026 Reset asserted mid-ROTATE or in DONE SHALL discard the in-flight request; no result is emitted after release.
REQ-027 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro ROTL_FAST_EN defined SHALL make each ROTATE cycle rotate by 2 when counter >= 2 (counter -= 2), else by 1; latency becomes 1 + ceil(select/2).
REQ-029 Without ROTL_FAST_EN the block SHALL behave exactly per REQ-016..REQ-018; handshake and reset behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset, data=4'b1001 select=1, out_ready=1 -> out_valid after 2 cycles, out=4'b0011, in_ready high one cycle later.
REQ-031 data=4'b1001 select=3 -> out=4'b1100 after 4 cycles (3 cycles with ROTL_FAST_EN).
REQ-032 data=4'b1010 select=0 -> out=4'b1010, out_valid 1 cycle after accept.
REQ-033 Result ready, out_ready held low 5 cycles, data/select/in_valid toggled -> out stable, in_ready 0, out taken on cycle 6.
REQ-034 Accept data=4'b0110 select=3, assert rst_n low in 2nd ROTATE cycle -> all outputs 0 immediately, no out_valid after release, next request processed correctly.
REQ-035 Randomized back-to-back requests, all select values -> out equals reference rotate-left, one result per accept, latency per REQ-018/REQ-028.

Source files
------------

// File: rtl/rotator_left_seq.sv
// Sequential left rotator: accepts a word and amount, rotates over several cycles, then holds the result until taken.
// Optional macro ROTL_FAST_EN: rotate by two positions per cycle while at least two remain.
module rotator_left_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q, busy_q;

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], w[WIDTH-1]};
    endfunction

    // State, working register and handshake flags; flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = data;
                    cnt_d   = select;
                    state_d = (select != '0) ? ROTATE : DONE;
                end
            end
            ROTATE: begin
`ifdef ROTL_FAST_EN
                if (32'(cnt_q) >= 32'd2) begin
                    work_d = rotl1(rotl1(work_q));
                    cnt_d  = cnt_q - AMT_W'(2);
                end else begin
                    work_d = rotl1(work_q);
                    cnt_d  = cnt_q - AMT_W'(1);
                end
`else
                work_d = rotl1(work_q);
                cnt_d  = cnt_q - AMT_W'(1);
`endif
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = work_q;

endmodule
